// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester, FIFO and status signals of fifo_wr_arbiter
interface fifo_wr_arbiter_if;
   logic        req0;
   logic [15:0] din0;
   logic        ack0;
   logic        req1;
   logic [15:0] din1;
   logic        ack1;
   logic        fifo_full;
   logic        fifo_almostfull;
   logic        fifo_wr;
   logic [15:0] fifo_din;
   logic [1:0]  grant;
   logic        busy;

   modport master (
      output req0, din0, req1, din1, fifo_full, fifo_almostfull,
      input  ack0, ack1, fifo_wr, fifo_din, grant, busy
   );

   modport slave (
      input  req0, din0, req1, din1, fifo_full, fifo_almostfull,
      output ack0, ack1, fifo_wr, fifo_din, grant, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - two-requester burst arbiter feeding a FIFO write port
// FIFO_ARB_FIXED_PRIO_EN: requester 0 wins every tie instead of round-robin on LAST.
module fifo_wr_arbiter #(
   parameter int BURST_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   fifo_wr_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BURST0 = 2'd1,
      BURST1 = 2'd2
   } state_t;

`ifdef FIFO_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   localparam logic [3:0] LEN = 4'(BURST_LEN);

   state_t      state, state_nx;
   logic        last, last_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        wr_q;
   logic [15:0] din_q;
   logic        space, ack0, ack1, acked, both;

   // A registered write still in flight takes the last slot signalled by almostfull.
   assign space = !bus.fifo_full && !(wr_q && bus.fifo_almostfull);
   assign ack0  = (state == BURST0) && bus.req0 && space;
   assign ack1  = (state == BURST1) && bus.req1 && space;
   assign acked = ack0 || ack1;
   assign both  = bus.req0 && bus.req1;

   always_comb begin
      state_nx = state;
      last_nx  = last;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            cnt_nx = 4'd0;
            if (both)
               state_nx = (FIXED_PRIO || last) ? BURST0 : BURST1;
            else if (bus.req0)
               state_nx = BURST0;
            else if (bus.req1)
               state_nx = BURST1;
         end
         BURST0: begin
            if (!bus.req0 || (ack0 && (cnt + 4'd1) == LEN)) begin
               last_nx = 1'b0;
               cnt_nx  = 4'd0;
               if (FIXED_PRIO && both)
                  state_nx = BURST0;
               else if (bus.req1)
                  state_nx = BURST1;
               else
                  state_nx = IDLE;
            end else if (ack0) begin
               cnt_nx = cnt + 4'd1;
            end
         end
         BURST1: begin
            if (!bus.req1 || (ack1 && (cnt + 4'd1) == LEN)) begin
               last_nx  = 1'b1;
               cnt_nx   = 4'd0;
               state_nx = bus.req0 ? BURST0 : IDLE;
            end else if (ack1) begin
               cnt_nx = cnt + 4'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= 4'd0;
         wr_q  <= 1'b0;
         din_q <= 16'd0;
      end else begin
         state <= state_nx;
         last  <= last_nx;
         cnt   <= cnt_nx;
         wr_q  <= acked;
         if (acked)
            din_q <= ack0 ? bus.din0 : bus.din1;
      end
   end

   assign bus.ack0     = ack0;
   assign bus.ack1     = ack1;
   assign bus.fifo_wr  = wr_q;
   assign bus.fifo_din = din_q;
   assign bus.grant    = {state == BURST1, state == BURST0};
   assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and randomized checks of fifo_wr_arbiter against an owner/word-count model
module tb_fifo_wr_arbiter;
`ifdef FIFO_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   localparam int LEN = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter_if bus ();
   fifo_wr_arbiter_if bus1 ();

   fifo_wr_arbiter #(.BURST_LEN(LEN)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   fifo_wr_arbiter #(.BURST_LEN(1))   u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: owner (-1 none), words served in current tenure, last served, pending write
   int          m_owner = -1;
   int          m_cnt   = 0;
   bit          m_last  = 1'b1;
   bit          m_wr    = 1'b0;
   logic [15:0] m_din   = 16'd0;
   int          n_owner, n_cnt, served;
   bit          n_last, e_space, e_ack0, e_ack1, mine, other;
   logic [1:0]  e_grant;

   always_comb begin
      e_space = !bus.fifo_full && !(m_wr && bus.fifo_almostfull);
      e_ack0  = (m_owner == 0) && bus.req0 && e_space;
      e_ack1  = (m_owner == 1) && bus.req1 && e_space;
      e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      n_owner = m_owner;
      n_cnt   = m_cnt;
      n_last  = m_last;
      served  = m_cnt + ((e_ack0 || e_ack1) ? 1 : 0);
      mine    = (m_owner == 0) ? bus.req0 : bus.req1;
      other   = (m_owner == 0) ? bus.req1 : bus.req0;
      if (m_owner < 0) begin
         n_cnt = 0;
         if (bus.req0 && bus.req1) n_owner = (FIXED || m_last) ? 0 : 1;
         else if (bus.req0)        n_owner = 0;
         else if (bus.req1)        n_owner = 1;
      end else if (!mine || served == LEN) begin
         n_cnt  = 0;
         n_last = (m_owner == 1);
         if (FIXED && bus.req0 && bus.req1) n_owner = 0;
         else if (other)                    n_owner = 1 - m_owner;
         else                               n_owner = -1;
      end else begin
         n_cnt = served;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner <= -1;
         m_cnt   <= 0;
         m_last  <= 1'b1;
         m_wr    <= 1'b0;
         m_din   <= 16'd0;
      end else begin
         m_owner <= n_owner;
         m_cnt   <= n_cnt;
         m_last  <= n_last;
         m_wr    <= e_ack0 || e_ack1;
         if (e_ack0)      m_din <= bus.din0;
         else if (e_ack1) m_din <= bus.din1;
      end
   end

   logic [1:0]  gtrace[$];
   logic [15:0] wtrace[$];
   bit          atrace[$];

   always @(negedge clk) begin
      chk("cycle", {bus.ack0, bus.ack1, bus.grant, bus.busy, bus.fifo_wr, bus.fifo_din},
                   {e_ack0, e_ack1, e_grant, m_owner >= 0, m_wr, m_din});
      if (gtrace.size() == 0 || gtrace[$] != bus.grant) gtrace.push_back(bus.grant);
      if (bus.fifo_wr) wtrace.push_back(bus.fifo_din);
      if (bus.ack0) atrace.push_back(1'b0);
      if (bus.ack1) atrace.push_back(1'b1);
   end

   function automatic logic [15:0] pack_g(input int n);
      logic [15:0] v = '0;
      for (int i = 0; i < n; i++)
         v[2*i +: 2] = (i < gtrace.size()) ? gtrace[i] : 2'b11;
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.req0 = 0; bus.req1 = 0; bus.fifo_full = 0; bus.fifo_almostfull = 0;
      bus1.req0 = 0; bus1.req1 = 0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      gtrace.delete(); wtrace.delete(); atrace.delete();
   endtask

   initial begin
      logic [19:0] vg;
      logic [9:0]  va, vm;
      logic [11:0] vb;
      logic [8:0]  v0, v1;
      bit          a0, a1;
      int          sent;

      rst = 1'b1;
      bus.din0 = 0; bus.din1 = 0; bus.req0 = 0; bus.req1 = 0;
      bus.fifo_full = 0; bus.fifo_almostfull = 0;
      bus1.din0 = 0; bus1.din1 = 0; bus1.req0 = 0; bus1.req1 = 0;
      bus1.fifo_full = 0; bus1.fifo_almostfull = 0;
      @(negedge clk);
      chk("reset_outputs", {bus.ack0, bus.ack1, bus.grant, bus.busy, bus.fifo_wr, bus.fifo_din}, 22'd0);

      // single requester, six words 0001..0006
      do_reset();
      bus.req0 = 1; bus.din0 = 16'h0001; sent = 0;
      for (int c = 0; c < 40 && sent < 6; c++) begin
         @(negedge clk); a0 = bus.ack0;
         @(posedge clk); #1;
         if (a0) begin
            sent++;
            if (sent == 6) bus.req0 = 0;
            else bus.din0 = 16'(sent + 1);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      chk("single_wcount", wtrace.size(), 6);
      for (int i = 0; i < 6; i++)
         chk("single_word", (i < wtrace.size()) ? wtrace[i] : 16'hxxxx, 16'(i + 1));
      chk("single_grants", pack_g(5), 16'h0044);

      // contention, 12 words
      do_reset();
      bus.req0 = 1; bus.req1 = 1; bus.din0 = 16'($urandom); bus.din1 = 16'($urandom); sent = 0;
      for (int c = 0; c < 60 && sent < 12; c++) begin
         @(negedge clk); a0 = bus.ack0; a1 = bus.ack1;
         @(posedge clk); #1;
         if (a0) bus.din0 = 16'($urandom);
         if (a1) bus.din1 = 16'($urandom);
         if (a0 || a1) sent++;
         if (sent == 12) begin bus.req0 = 0; bus.req1 = 0; end
      end
      repeat (3) @(posedge clk);
      #1;
      vb = '0;
      for (int i = 0; i < 12; i++) vb[i] = (i < atrace.size()) ? atrace[i] : 1'bx;
      chk("contention_owners", vb, FIXED ? 12'h000 : 12'h0F0);
      chk("contention_grants", pack_g(4), FIXED ? 16'h00C4 : 16'h0064);

      // almostfull then full stall
      do_reset();
      bus.fifo_almostfull = 1; bus.req0 = 1; bus.din0 = 16'h00C0;
      vg = '0; va = '0; vm = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); va[c] = bus.ack0; vm[c] = e_ack0; vg[2*c +: 2] = bus.grant;
         @(posedge clk); #1;
         if (c == 3) begin bus.fifo_almostfull = 0; bus.fifo_full = 1; end
         if (c == 6) bus.fifo_full = 0;
      end
      bus.req0 = 0;
      chk("stall_acks", va, 10'h18A);
      chk("stall_model_acks", vm, 10'h18A);
      chk("stall_grants", vg, 20'h15554);

      // requester 1 releases after two words, then both request
      do_reset();
      bus.req1 = 1; bus.din1 = 16'hB001;
      vg = '0; va = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); va[c] = bus.ack1; vg[2*c +: 2] = bus.grant;
         @(posedge clk); #1;
         if (c == 2) bus.req1 = 0;
         if (c == 3) begin bus.req0 = 1; bus.req1 = 1; end
      end
      bus.req0 = 0; bus.req1 = 0;
      chk("release_acks", va[5:0], 6'b000110);
      chk("release_grants", vg[11:0], 12'h4A8);

      // reset in the middle of the second burst
      do_reset();
      bus.req0 = 1; bus.din0 = 16'hE5E5;
      repeat (8) begin @(negedge clk); @(posedge clk); end
      #1;
      chk("pre_reset_wr", bus.fifo_wr, 1'b1);
      rst = 1'b1; bus.req1 = 1;
      #1;
      chk("mid_reset_outputs", {bus.ack0, bus.ack1, bus.grant, bus.busy, bus.fifo_wr, bus.fifo_din}, 22'd0);
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); chk("post_reset_idle", bus.grant, 2'b00);
      @(negedge clk); chk("post_reset_grant", bus.grant, 2'b01);
      @(posedge clk); #1;
      bus.req0 = 0; bus.req1 = 0;

      // BURST_LEN=1 alternation
      do_reset();
      bus1.req0 = 1; bus1.req1 = 1;
      v0 = '0; v1 = '0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk); v0[c] = bus1.ack0; v1[c] = bus1.ack1;
         @(posedge clk); #1;
         bus1.din0 = 16'($urandom); bus1.din1 = 16'($urandom);
      end
      bus1.req0 = 0; bus1.req1 = 0;
      chk("len1_ack0", v0, FIXED ? 9'h1FE : 9'h0AA);
      chk("len1_ack1", v1, FIXED ? 9'h000 : 9'h154);
      chk("len1_overlap", v0 & v1, 9'h000);

      // randomized traffic, checked cycle by cycle against the model
      for (int r = 0; r < 2; r++) begin
         do_reset();
         repeat (1500) begin
            @(negedge clk); a0 = bus.ack0; a1 = bus.ack1;
            @(posedge clk); #1;
            if (!bus.req0 || a0) begin bus.req0 = ($urandom_range(0, 3) != 0); bus.din0 = 16'($urandom); end
            if (!bus.req1 || a1) begin bus.req1 = ($urandom_range(0, 3) != 0); bus.din1 = 16'($urandom); end
            bus.fifo_full       = ($urandom_range(0, 7) == 0);
            bus.fifo_almostfull = ($urandom_range(0, 3) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4, max words granted per requester per tenure; legal range 1..15.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 REQ0  input  1  requester 0 has a word on DIN0.
REQ-005 DIN0  input  16  requester 0 data.
REQ-006 ACK0  output  1  combinational; DIN0 accepted this cycle.
REQ-007 REQ1  input  1  requester 1 has a word on DIN1.
REQ-008 DIN1  input  16  requester 1 data.
REQ-009 ACK1  output  1  combinational; DIN1 accepted this cycle.
REQ-010 FIFO_FULL  input  1  FIFO FULL flag.
REQ-011 FIFO_ALMOSTFULL  input  1  FIFO almostFULL flag; asserted when one free slot remains.
REQ-012 FIFO_WR  output  1  registered write strobe to FIFO WR.
REQ-013 FIFO_DIN  output  16  registered data to FIFO DIN.
REQ-014 GRANT  output  2  one-hot current owner: 01 = requester 0, 10 = requester 1, 00 = none.
REQ-015 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, BURST0, BURST1; GRANT and BUSY decode the state directly.
REQ-017 IDLE: with one request, go to that requester's BURST state; with both, go to the requester not served last (round-robin pointer LAST; LAST=1 after reset, so requester 0 wins first).
REQ-018 Space condition SPACE = !FIFO_FULL && !(FIFO_WR && FIFO_ALMOSTFULL), which covers the in-flight registered write.
REQ-019 ACKn = (state==BURSTn) && REQn && SPACE; at most one ACK high in any cycle.
REQ-020 Acked word registered: next cycle FIFO_WR=1 and FIFO_DIN=DINn; otherwise FIFO_WR=0 and FIFO_DIN holds its value.
REQ-021 4-bit burst counter cleared on BURST entry and incremented on each ACK.
REQ-022 BURSTn ends when the ACK makes the count reach BURST_LEN, or when REQn is low; a stall on !SPACE with REQn high does not end the burst.
REQ-023 On burst end LAST<=n; go to BURST of the other requester if its REQ is high that cycle, else go to IDLE.
REQ-024 No ACK is issued in IDLE; a burst starts acking the cycle after entry.
REQ-025 Requesters hold REQn and DINn stable until ACKn; the block does not buffer unacked words.

Reset
REQ-026 RST high asynchronously forces state IDLE, LAST=1, counter 0, FIFO_WR=0, FIFO_DIN=0, GRANT=00, BUSY=0, ACK0=ACK1=0.
REQ-027 Reset mid-burst discards the burst; any write registered but not yet presented is dropped, so FIFO_WR is low while RST is high.
REQ-028 The first grant after RST deasserts occurs no earlier than the first rising edge with RST low.

Configuration
REQ-029 Macro FIFO_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins when both are requesting, in IDLE and at burst end, and LAST is ignored; when undefined, the round-robin of REQ-017/REQ-023 applies.

Verification
REQ-030 Single requester: REQ0 held, DIN0=16'h0001..0006, BURST_LEN=4, FIFO empty -> four ACK0, BURST0 to IDLE to BURST0, FIFO_WR writes 0001..0006 in order, one cycle after each ACK.
REQ-031 Contention: REQ0 and REQ1 both held from reset -> GRANT sequence 01,10,01 with 4 words each, no IDLE gap between bursts (macro undefined); with macro defined, GRANT stays 01.
REQ-032 Full stall: FIFO_ALMOSTFULL=1 while a write is in flight -> ACK0 low next cycle; FIFO_FULL=1 for 3 cycles -> no ACK and state unchanged; release -> ACK resumes, burst count preserved.
REQ-033 Early release: REQ1 drops after 2 words with BURST_LEN=4 -> BURST1 ends, LAST=1, next grant goes to requester 0.
REQ-034 Reset mid-burst: RST pulsed after the 2nd ACK0 -> all outputs 0 immediately, no further FIFO_WR, requester 0 regranted first after release.
REQ-035 BURST_LEN=1 with both requesters held -> strict alternation, one word each, ACK0 and ACK1 never high together.
